// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug bridge: 8N1 command frames on uart_rx drive single
// 32-bit Wishbone cycles; a status byte or the read data returns on uart_tx.
module uart_wb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    output logic [ADDR_WIDTH-1:0] wbm_addr,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    output logic                  wbm_we,
    output logic [3:0]            wbm_sel,
    output logic                  wbm_stb,
    input  logic                  wbm_ack,
    output logic                  busy
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

    rx_state_t       rx_state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_byte_q;
    logic            rx_stop_tick, rx_valid, rx_ferr;

    p_state_t        p_state_q;
    logic            cmd_we_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     addr_q, data_q, resp_q;
    logic [2:0]      resp_left_q;
    logic [TW-1:0]   to_cnt_q;
    logic [31:0]     addr_d, data_d;
    logic [ADDR_WIDTH-1:0] wbm_addr_q;
    logic [31:0]     wbm_dat_o_q;
    logic            wbm_we_q, wbm_stb_q;
    logic [3:0]      wbm_sel_q;

    logic            tx_q, tx_active_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_last, tx_take;

    // Stop bit is judged directly at its sample point so the bus cycle can
    // start on the very next clock.
    assign rx_stop_tick = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_LAST);
    assign rx_valid     = rx_stop_tick && rx_sync_q;
    assign rx_ferr      = rx_stop_tick && !rx_sync_q;
    assign addr_d       = {addr_q[23:0], rx_byte_q};
    assign data_d       = {data_q[23:0], rx_byte_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_state_q <= RX_START;
                    rx_cnt_q   <= '0;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
                RX_DATA: if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_q  <= '0;
                    rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
                default: if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                end else rx_cnt_q <= rx_cnt_q + CW'(1);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= P_IDLE;
            cmd_we_q    <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            to_cnt_q    <= '0;
            wbm_addr_q  <= '0;
            wbm_dat_o_q <= '0;
            wbm_we_q    <= 1'b0;
            wbm_stb_q   <= 1'b0;
            wbm_sel_q   <= 4'h0;
        end else begin
            case (p_state_q)
                P_IDLE: if (rx_valid) begin
                    byte_cnt_q <= '0;
                    if (rx_byte_q == 8'h57 || rx_byte_q == 8'h52) begin
                        cmd_we_q  <= (rx_byte_q == 8'h57);
                        p_state_q <= P_ADDR;
                    end else begin
                        resp_q      <= {8'h3F, 24'h0};
                        resp_left_q <= 3'd1;
                        p_state_q   <= P_RESP;
                    end
                end
                P_ADDR: if (rx_ferr) p_state_q <= P_IDLE;
                else if (rx_valid) begin
                    addr_q     <= addr_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (cmd_we_q) p_state_q <= P_DATA;
                        else begin
                            wbm_stb_q   <= 1'b1;
                            wbm_we_q    <= 1'b0;
                            wbm_sel_q   <= 4'hF;
                            wbm_addr_q  <= addr_d[ADDR_WIDTH-1:0];
                            wbm_dat_o_q <= data_q;
                            to_cnt_q    <= '0;
                            p_state_q   <= P_BUS;
                        end
                    end
                end
                P_DATA: if (rx_ferr) p_state_q <= P_IDLE;
                else if (rx_valid) begin
                    data_q     <= data_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wbm_stb_q   <= 1'b1;
                        wbm_we_q    <= 1'b1;
                        wbm_sel_q   <= 4'hF;
                        wbm_addr_q  <= addr_q[ADDR_WIDTH-1:0];
                        wbm_dat_o_q <= data_d;
                        to_cnt_q    <= '0;
                        p_state_q   <= P_BUS;
                    end
                end
                // Ack is checked before the timeout so an ack on the last
                // allowed cycle still succeeds.
                P_BUS: if (wbm_ack || to_cnt_q == TO_LAST) begin
                    wbm_stb_q   <= 1'b0;
                    wbm_we_q    <= 1'b0;
                    wbm_sel_q   <= 4'h0;
                    p_state_q   <= P_RESP;
                    if (!wbm_ack) begin
                        resp_q      <= {8'h45, 24'h0};
                        resp_left_q <= 3'd1;
                    end else if (cmd_we_q) begin
                        resp_q      <= {8'h4B, 24'h0};
                        resp_left_q <= 3'd1;
                    end else begin
                        resp_q      <= wbm_dat_i;
                        resp_left_q <= 3'd4;
                    end
                end else to_cnt_q <= to_cnt_q + TW'(1);
                default: if (tx_take) begin
                    resp_q      <= {resp_q[23:0], 8'h00};
                    resp_left_q <= resp_left_q - 3'd1;
                end else if (resp_left_q == 3'd0 && !tx_active_q) p_state_q <= P_IDLE;
            endcase
        end
    end

    // A pending byte is loaded on the last stop-bit cycle, so responses
    // leave back-to-back with no idle gap.
    assign tx_last = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DIV_LAST);
    assign tx_take = (!tx_active_q || tx_last) && (p_state_q == P_RESP) && (resp_left_q != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
        end else if (tx_take) begin
            tx_q        <= 1'b0;
            tx_active_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= resp_q[31:24];
        end else if (tx_active_q) begin
            if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) tx_active_q <= 1'b0;
                else begin
                    tx_bit_q   <= tx_bit_q + 4'd1;
                    tx_q       <= (tx_bit_q == 4'd8) ? 1'b1 : tx_shift_q[0];
                    tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                end
            end else tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    assign uart_tx   = tx_q;
    assign wbm_addr  = wbm_addr_q;
    assign wbm_dat_o = wbm_dat_o_q;
    assign wbm_we    = wbm_we_q;
    assign wbm_sel   = wbm_sel_q;
    assign wbm_stb   = wbm_stb_q;
    assign busy      = (p_state_q != P_IDLE);
endmodule
